if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address of first fetch after reset.
REQ-002 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 PCWrite  input  1  hazard-unit advance enable; 0 = IF/ID stalled, buffered instruction must be held.
REQ-005 Redirect  input  1  one-cycle pulse; branch/jump taken, fetch must restart at RedirectTarget.
REQ-006 RedirectTarget  input  32  new fetch address; bits [1:0] ignored and forced to 00.
REQ-007 IMem_Req  output  1  fetch request to instruction memory.
REQ-008 IMem_Addr  output  32  word-aligned fetch address.
REQ-009 IMem_Ready  input  1  memory completes transfer; IMem_Data valid this cycle.
REQ-010 IMem_Data  input  32  instruction word.
REQ-011 IF_Instruction  output  32  buffered instruction to IF/ID; 32'd0 (NOP) when IF_Valid=0.
REQ-012 IF_PCplus4  output  32  buffered instruction address + 4; 32'd0 when IF_Valid=0.
REQ-013 IF_Valid  output  1  buffer holds a live instruction.

Function
REQ-014 Transfer SHALL occur exactly in cycles where IMem_Req=1 and IMem_Ready=1; IMem_Ready with IMem_Req=0 is ignored.
REQ-015 IMem_Addr SHALL equal the PC register and SHALL remain stable while IMem_Req=1 until a transfer completes.
REQ-016 States: FETCH, DRAIN.
REQ-017 FETCH: IMem_Req = !(IF_Valid && !PCWrite); on transfer without Redirect: buffer <= IMem_Data, buffer address <= PC, IF_Valid <= 1, PC <= PC+4 (32-bit wrap).
REQ-018 FETCH: when IF_Valid=1, PCWrite=1 and no transfer, IF_Valid <= 0 at the edge (buffer consumed).
REQ-019 Latency: instruction appears on IF_Instruction the cycle after its transfer; back-to-back transfers with PCWrite=1 give one instruction per cycle.
REQ-020 Redirect in FETCH with IMem_Req=0 or with a transfer in the same cycle: transferred data discarded, IF_Valid <= 0, PC <= target, remain FETCH.
REQ-021 Redirect in FETCH with IMem_Req=1 and no transfer: IF_Valid <= 0, pending target <= RedirectTarget, next state DRAIN.
REQ-022 DRAIN: IMem_Req=1 at old PC, IF_Valid=0; on transfer data discarded, PC <= pending target, next state FETCH.
REQ-023 Redirect during DRAIN SHALL overwrite the pending target (latest wins); state unchanged.
REQ-024 Redirect SHALL take priority over PCWrite=0 and over buffer capture.
REQ-025 No more than one outstanding request; no instruction from a squashed path ever reaches IF_Valid=1.

Reset
REQ-026 Reset low: PC <= RESET_PC, state <= FETCH, IF_Valid <= 0, buffer and pending target <= 0, immediately and regardless of Clock.
REQ-027 Reset asserted mid-DRAIN or mid-request SHALL abandon the request; IMem_Req=1 at RESET_PC in the first cycle after release.

Structure
REQ-028 Shared pipeline package SHALL hold the state enum (FETCH, DRAIN), NOP word 32'd0 and instruction byte width 4.
REQ-029 One sub-module SHALL be natural: if_inst_buffer (single-entry instruction/address register with valid, load, consume, clear).

Verification
REQ-030 Reset release, IMem_Ready always 1, PCWrite=1 -> IMem_Addr 0,4,8; IF_PCplus4 4,8,12 one cycle later each.
REQ-031 IF_Valid=1 at PC 0x8, PCWrite=0 for 3 cycles -> IMem_Req=0, IF_Instruction held, IMem_Addr stays 0xC.
REQ-032 Redirect to 0x100 while IMem_Req=1, IMem_Ready=0 for 2 cycles -> DRAIN; old word discarded; next IMem_Addr 0x100.
REQ-033 Redirect to 0x200 same cycle as transfer at 0x10 -> IF_Valid=0 next cycle, next IMem_Addr 0x200.
REQ-034 Two Redirects (0x300 then 0x400) during DRAIN -> fetch resumes at 0x400 only.
REQ-035 Reset low mid-DRAIN -> IF_Valid=0 asynchronously; after release IMem_Addr=RESET_PC; PC 0xFFFF_FFFC increments wrap to 0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch unit and its instruction buffer.
package if_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP        = 32'd0;
  localparam logic [31:0] INST_BYTES = 32'd4;

  function automatic logic [31:0] align_word(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_buf.sv
// Single-entry instruction/address holding register.
// Priority: clear, then load, then consume.
import if_fetch_pkg::*;

module if_inst_buffer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_consume,
  input  logic        i_clear,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_addr,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pcplus4
);

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_inst  <= NOP;
      r_addr  <= 32'd0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_addr  <= i_addr;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_inst    = r_valid ? r_inst : NOP;
  assign o_pcplus4 = r_valid ? r_addr + INST_BYTES : 32'd0;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding request, redirect
// squashing via DRAIN while an old request is still pending.
import if_fetch_pkg::*;

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ready,
  input  logic [31:0] IMem_Data,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PCplus4,
  output logic        IF_Valid
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_pend, w_pend_nxt;
  logic [31:0]  w_tgt;
  logic         w_req, w_xfer;
  logic         w_load, w_consume, w_clear;
  logic         w_valid;

  assign w_tgt = align_word(RedirectTarget);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_pend  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_req       = 1'b1;
    w_xfer      = 1'b0;
    w_load      = 1'b0;
    w_consume   = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_req  = !(w_valid && !PCWrite);
        w_xfer = w_req && IMem_Ready;
        if (Redirect) begin
          w_clear = 1'b1;
          if (!w_req || w_xfer) begin
            w_pc_nxt = w_tgt;
          end else begin
            w_pend_nxt  = w_tgt;
            w_state_nxt = DRAIN;
          end
        end else if (w_xfer) begin
          w_load   = 1'b1;
          w_pc_nxt = r_pc + INST_BYTES;
        end else if (w_valid && PCWrite) begin
          w_consume = 1'b1;
        end
      end
      DRAIN: begin
        w_clear = 1'b1;
        w_xfer  = IMem_Ready;
        if (Redirect) w_pend_nxt = w_tgt;
        // A redirect landing on the drain beat still wins.
        if (w_xfer) begin
          w_pc_nxt    = Redirect ? w_tgt : r_pend;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  if_inst_buffer u_buf (
    .i_clk     (Clock),
    .i_rst_n   (Reset),
    .i_load    (w_load),
    .i_consume (w_consume),
    .i_clear   (w_clear),
    .i_inst    (IMem_Data),
    .i_addr    (r_pc),
    .o_valid   (w_valid),
    .o_inst    (IF_Instruction),
    .o_pcplus4 (IF_PCplus4)
  );

  assign IMem_Req  = w_req;
  assign IMem_Addr = r_pc;
  assign IF_Valid  = w_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed scenarios plus randomized run against a
// transaction-level model of the fetch unit.
module tb_if_fetch_unit;

  localparam logic [31:0] RP = 32'h0000_0000;

  logic        Clock, Reset, PCWrite, Redirect;
  logic [31:0] RedirectTarget, IMem_Addr, IMem_Data;
  logic        IMem_Req, IMem_Ready, IF_Valid;
  logic [31:0] IF_Instruction, IF_PCplus4;

  int n_pass = 0;
  int n_total = 0;

  if_fetch_unit #(.RESET_PC(RP)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .PCWrite        (PCWrite),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .IMem_Req       (IMem_Req),
    .IMem_Addr      (IMem_Addr),
    .IMem_Ready     (IMem_Ready),
    .IMem_Data      (IMem_Data),
    .IF_Instruction (IF_Instruction),
    .IF_PCplus4     (IF_PCplus4),
    .IF_Valid       (IF_Valid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic apply(input logic pcw, input logic red,
                       input logic [31:0] tgt, input logic rdy,
                       input logic [31:0] data);
    PCWrite = pcw; Redirect = red; RedirectTarget = tgt;
    IMem_Ready = rdy; IMem_Data = data;
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    @(posedge Clock); #2;
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    Reset = 1'b0;
    #1;
    n_total++; if (IF_Valid !== 1'b0) $display("FAIL rst_valid got %b want 0", IF_Valid); else n_pass++;
    n_total++; if (IMem_Addr !== RP) $display("FAIL rst_addr got %h want %h", IMem_Addr, RP); else n_pass++;
    n_total++; if (IF_Instruction !== 32'h0) $display("FAIL rst_inst got %h want 0", IF_Instruction); else n_pass++;
    n_total++; if (IF_PCplus4 !== 32'h0) $display("FAIL rst_pc4 got %h want 0", IF_PCplus4); else n_pass++;
    Reset = 1'b1;
    #1;
    n_total++; if (IMem_Req !== 1'b1) $display("FAIL rst_req got %b want 1", IMem_Req); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] d [0:3];
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b1, d[i]);
      if (i < 3) begin
        n_total++; if (IMem_Addr !== 32'(4 * i)) $display("FAIL seq_addr got %h want %h", IMem_Addr, 32'(4 * i)); else n_pass++;
      end
      if (i > 0) begin
        n_total++; if (IF_PCplus4 !== 32'(4 * i)) $display("FAIL seq_pc4 got %h want %h", IF_PCplus4, 32'(4 * i)); else n_pass++;
        n_total++; if (IF_Instruction !== d[i-1]) $display("FAIL seq_inst got %h want %h", IF_Instruction, d[i-1]); else n_pass++;
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = IF_Instruction;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
      n_total++; if (IMem_Req !== 1'b0) $display("FAIL stall_req got %b want 0", IMem_Req); else n_pass++;
      n_total++; if (IMem_Addr !== 32'hC) $display("FAIL stall_addr got %h want c", IMem_Addr); else n_pass++;
      n_total++; if (IF_Instruction !== held || IF_PCplus4 !== 32'hC) $display("FAIL stall_hold got %h/%h want %h/c", IF_Instruction, IF_PCplus4, held); else n_pass++;
      tick();
    end
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    n_total++; if (IF_Valid !== 1'b0) $display("FAIL consume_valid got %b want 0", IF_Valid); else n_pass++;
  endtask

  task automatic test_redirect_drain();
    apply(1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    n_total++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'hC) $display("FAIL drain_req got %b/%h want 1/c", IMem_Req, IMem_Addr); else n_pass++;
    tick();
    apply(1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    n_total++; if (IF_Valid !== 1'b0) $display("FAIL drain_valid got %b want 0", IF_Valid); else n_pass++;
    tick();
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    n_total++; if (IMem_Addr !== 32'h100) $display("FAIL drain_next got %h want 100", IMem_Addr); else n_pass++;
    n_total++; if (IF_Valid !== 1'b0) $display("FAIL drain_discard got %b want 0", IF_Valid); else n_pass++;
  endtask

  task automatic test_redirect_xfer();
    apply(1'b1, 1'b1, 32'h10, 1'b1, 32'h1111_1111);
    tick();
    apply(1'b1, 1'b1, 32'h200, 1'b1, 32'h2222_2222);
    n_total++; if (IMem_Addr !== 32'h10) $display("FAIL rx_addr got %h want 10", IMem_Addr); else n_pass++;
    tick();
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    n_total++; if (IF_Valid !== 1'b0) $display("FAIL rx_valid got %b want 0", IF_Valid); else n_pass++;
    n_total++; if (IMem_Addr !== 32'h200) $display("FAIL rx_next got %h want 200", IMem_Addr); else n_pass++;
  endtask

  task automatic test_double_redirect();
    apply(1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    apply(1'b1, 1'b1, 32'h403, 1'b0, 32'h0);
    tick();
    apply(1'b1, 1'b0, 32'h0, 1'b1, 32'h3333_3333);
    n_total++; if (IMem_Addr !== 32'h200) $display("FAIL dd_hold got %h want 200", IMem_Addr); else n_pass++;
    tick();
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    n_total++; if (IMem_Addr !== 32'h400) $display("FAIL dd_next got %h want 400", IMem_Addr); else n_pass++;
    n_total++; if (IF_Valid !== 1'b0) $display("FAIL dd_valid got %b want 0", IF_Valid); else n_pass++;
  endtask

  task automatic test_reset_wrap();
    logic [31:0] w;
    apply(1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    #2 Reset = 1'b0;
    #1;
    n_total++; if (IF_Valid !== 1'b0 || IMem_Addr !== RP) $display("FAIL rd_async got %b/%h want 0/%h", IF_Valid, IMem_Addr, RP); else n_pass++;
    Reset = 1'b1;
    apply(1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    n_total++; if (IMem_Req !== 1'b1 || IMem_Addr !== RP) $display("FAIL rd_restart got %b/%h want 1/%h", IMem_Req, IMem_Addr, RP); else n_pass++;
    tick();
    #2 Reset = 1'b0;
    #1;
    n_total++; if (IF_Valid !== 1'b0) $display("FAIL rv_async got %b want 0", IF_Valid); else n_pass++;
    Reset = 1'b1;
    apply(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0);
    tick();
    w = $urandom;
    apply(1'b1, 1'b0, 32'h0, 1'b1, w);
    n_total++; if (IMem_Addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h want fffffffc", IMem_Addr); else n_pass++;
    tick();
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    n_total++; if (IMem_Addr !== 32'h0) $display("FAIL wrap_pc got %h want 0", IMem_Addr); else n_pass++;
    n_total++; if (IF_PCplus4 !== 32'h0 || IF_Instruction !== w || IF_Valid !== 1'b1) $display("FAIL wrap_buf got %h/%h/%b want 0/%h/1", IF_PCplus4, IF_Instruction, IF_Valid, w); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_inst, m_addr, m_tgt, tgt, data;
    logic        m_valid, m_squash, pcw, red, rdy, req, xfer;
    #2 Reset = 1'b0;
    #1 Reset = 1'b1;
    m_pc = RP; m_valid = 1'b0; m_squash = 1'b0;
    m_inst = 32'h0; m_addr = 32'h0; m_tgt = 32'h0;
    for (int c = 0; c < 400; c++) begin
      pcw  = ($urandom_range(3) != 0);
      red  = ($urandom_range(6) == 0);
      rdy  = $urandom_range(1);
      tgt  = $urandom;
      data = $urandom;
      apply(pcw, red, tgt, rdy, data);
      req = m_squash || !(m_valid && !pcw);
      n_total++; if (IMem_Req !== req) $display("FAIL rnd_req c%0d got %b want %b", c, IMem_Req, req); else n_pass++;
      n_total++; if (IMem_Addr !== m_pc) $display("FAIL rnd_addr c%0d got %h want %h", c, IMem_Addr, m_pc); else n_pass++;
      n_total++; if (IF_Valid !== m_valid) $display("FAIL rnd_valid c%0d got %b want %b", c, IF_Valid, m_valid); else n_pass++;
      n_total++; if (IF_Instruction !== (m_valid ? m_inst : 32'h0)) $display("FAIL rnd_inst c%0d got %h want %h", c, IF_Instruction, m_valid ? m_inst : 32'h0); else n_pass++;
      n_total++; if (IF_PCplus4 !== (m_valid ? m_addr + 32'd4 : 32'h0)) $display("FAIL rnd_pc4 c%0d got %h want %h", c, IF_PCplus4, m_valid ? m_addr + 32'd4 : 32'h0); else n_pass++;
      tick();
      xfer = req && rdy;
      tgt  = tgt & 32'hFFFF_FFFC;
      if (m_squash) begin
        if (red) m_tgt = tgt;
        if (xfer) begin m_pc = m_tgt; m_squash = 1'b0; end
      end else if (red) begin
        m_valid = 1'b0;
        if (xfer || !req) m_pc = tgt;
        else begin m_squash = 1'b1; m_tgt = tgt; end
      end else if (xfer) begin
        m_inst = data; m_addr = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else if (m_valid && pcw) begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    Reset = 1'b1; PCWrite = 1'b1; Redirect = 1'b0;
    RedirectTarget = 32'h0; IMem_Ready = 1'b0; IMem_Data = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drain();
    test_redirect_xfer();
    test_double_redirect();
    test_reset_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
